// File: rtl/sprite_blitter.sv
// Draws an SPR_W x SPR_H sprite from a 1-cycle-latency ROM to the VGA adapter,
// with mirroring and off-screen clipping. Define SPRITE_TRANSPARENT_EN to skip key-colour pixels.
module sprite_blitter #(
    parameter int SPR_W       = 5,
    parameter int SPR_H       = 5,
    parameter int ADDR_W      = 7,
    parameter int COLOUR_W    = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int TRANSPARENT = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mirror,
    input  logic [7:0]          startx,
    input  logic [6:0]          starty,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CXW-1:0] CX_LAST = CXW'(SPR_W - 1);
    localparam logic [CYW-1:0] CY_LAST = CYW'(SPR_H - 1);
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(TRANSPARENT);
`ifdef SPRITE_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]     lat_x;
    logic [6:0]     lat_y;
    logic [1:0]     lat_mirror;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [CXW-1:0] sx;
    logic [CYW-1:0] sy;
    logic [8:0]     x_sum;
    logic [7:0]     y_sum;
    logic           in_screen;
    logic           last_pixel;
    logic           plot_q;
    logic           pix_valid;

    assign last_pixel = (cx == CX_LAST) && (cy == CY_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SCAN;
            S_SCAN:  if (last_pixel) state_next = S_FLUSH;
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Origin and mirroring are captured once so callers may move on immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_x      <= '0;
            lat_y      <= '0;
            lat_mirror <= '0;
        end else if (state == S_IDLE && start) begin
            lat_x      <= startx;
            lat_y      <= starty;
            lat_mirror <= mirror;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (state == S_SCAN) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                cy <= (cy == CY_LAST) ? '0 : cy + CYW'(1);
            end else begin
                cx <= cx + CXW'(1);
            end
        end else begin
            cx <= '0;
            cy <= '0;
        end
    end

    always_comb begin
        sx        = lat_mirror[0] ? (CX_LAST - cx) : cx;
        sy        = lat_mirror[1] ? (CY_LAST - cy) : cy;
        rom_addr  = ADDR_W'(sy) * ADDR_W'(SPR_W) + ADDR_W'(sx);
        x_sum     = {1'b0, lat_x} + 9'(cx);
        y_sum     = {1'b0, lat_y} + 8'(cy);
        in_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
    end

    // Coordinates are registered alongside the ROM read so they line up with rom_data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            plot_q    <= 1'b0;
            pix_valid <= 1'b0;
        end else if (state == S_SCAN) begin
            x         <= x_sum[7:0];
            y         <= y_sum[6:0];
            plot_q    <= in_screen;
            pix_valid <= 1'b1;
        end else begin
            plot_q    <= 1'b0;
            pix_valid <= 1'b0;
        end
    end

    assign colour = pix_valid ? rom_data : '0;
    assign plot   = plot_q && !(KEY_EN && (rom_data == KEY_COLOUR));
    assign busy   = (state == S_SCAN) || (state == S_FLUSH);
    assign done   = (state == S_DONE);

endmodule
